// File: rtl/y86_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : y86_mem_port_if
// Brief    : Loader handshake and y86_seq core bus bundle for y86_mem_port.
// Revision : 1.0
// ============================================================================
interface y86_mem_port_if #(
    parameter int ADDR_W = 12
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              core_rst;
    logic [31:0]       bus_A;
    logic [31:0]       bus_in;
    logic [31:0]       bus_out;
    logic              bus_WE;
    logic              bus_RE;
    logic [7:0]        current_opcode;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        input  bus_A, bus_out, bus_WE, bus_RE, current_opcode,
        output ld_ready, core_rst, bus_in
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        output bus_A, bus_out, bus_WE, bus_RE, current_opcode,
        input  ld_ready, core_rst, bus_in
    );
endinterface
`default_nettype wire

// File: rtl/y86_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : y86_mem_port
// Brief    : Byte-addressed unified memory for y86_seq with boot loader,
//            core reset release, access counters and halt/error flags.
// Revision : 1.0
// ============================================================================
module y86_mem_port #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    y86_mem_port_if.slave    mp,
    output logic             halted,
    output logic             addr_err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);
    localparam logic [7:0] HALT_OPCODE = 8'hF4;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             core_rst_q, core_rst_d;
    logic             halted_q, halted_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] w_byte_addr [4];
    logic              w_run;
    logic              w_in_range;
    logic              w_ld_en;
    logic              w_wr_en;
    logic              w_rd_en;

    // Byte lanes wrap modulo the array size, so unaligned/edge accesses are legal.
    for (genvar g = 0; g < 4; g++) begin : g_byte_addr
        assign w_byte_addr[g] = mp.bus_A[ADDR_W-1:0] + ADDR_W'(g);
    end

    assign w_run      = (state_q == S_RUN);
    assign w_in_range = (mp.bus_A[31:ADDR_W] == '0);
    assign w_ld_en    = mp.ld_valid && (state_q == S_LOAD);
    assign w_wr_en    = w_run && mp.bus_WE && w_in_range;
    assign w_rd_en    = w_run && mp.bus_RE && w_in_range;

    assign mp.ld_ready = (state_q == S_LOAD);
    assign mp.core_rst = core_rst_q;
    assign mp.bus_in   = w_rd_en ? {mem[w_byte_addr[3]], mem[w_byte_addr[2]],
                                    mem[w_byte_addr[1]], mem[w_byte_addr[0]]} : 32'h0;

    assign halted   = halted_q;
    assign addr_err = addr_err_q;
    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        addr_err_d = addr_err_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        case (state_q)
            S_LOAD:    if (w_ld_en && mp.ld_last) state_d = S_RELEASE;
            S_RELEASE: state_d = S_RUN;
            S_RUN:     state_d = S_RUN;
            default:   state_d = S_LOAD;
        endcase

        // Registered so the core sees reset through the whole RELEASE cycle.
        core_rst_d = (state_d != S_RUN);

        if (w_run && !core_rst_q && (mp.current_opcode == HALT_OPCODE))
            halted_d = 1'b1;
        if (w_run && (((mp.bus_WE || mp.bus_RE) && !w_in_range) || (mp.bus_WE && mp.bus_RE)))
            addr_err_d = 1'b1;
        if (w_rd_en && (rd_cnt_q != '1))
            rd_cnt_d = rd_cnt_q + 1'b1;
        if (w_wr_en && (wr_cnt_q != '1))
            wr_cnt_d = wr_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            core_rst_q <= 1'b1;
            halted_q   <= 1'b0;
            addr_err_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            halted_q   <= halted_d;
            addr_err_q <= addr_err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Array contents survive rst so a reload can patch a running image.
    always_ff @(posedge clk) begin
        if (w_ld_en) begin
            mem[mp.ld_addr] <= mp.ld_data;
        end else if (w_wr_en) begin
            for (int i = 0; i < 4; i++)
                mem[w_byte_addr[i]] <= mp.bus_out[8*i +: 8];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_y86_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_mem_port
// Brief    : Randomized self-checking bench for y86_mem_port against a
//            byte-array reference model.
// Revision : 1.0
// ============================================================================
module tb_y86_mem_port;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 32;
    localparam int MEM_SZ = 2**ADDR_W;

    logic             clk;
    logic             rst;
    logic             halted;
    logic             addr_err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    y86_mem_port_if #(.ADDR_W(ADDR_W)) bus_if ();

    y86_mem_port #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mp       (bus_if),
        .halted   (halted),
        .addr_err (addr_err),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    // Reference model: phase 0=load, 1=release, 2=run
    logic [7:0]  m_mem [0:MEM_SZ-1];
    int          m_phase;
    logic        m_halt;
    logic        m_err;
    logic [31:0] m_rd;
    logic [31:0] m_wr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
        logic [11:0] idx;
        if (m_phase != 2 || !re || a[31:12] != 20'h0) return 32'h0;
        idx = a[11:0];
        return {m_mem[idx + 12'd3], m_mem[idx + 12'd2], m_mem[idx + 12'd1], m_mem[idx]};
    endfunction

    task automatic m_reset();
        m_phase = 0;
        m_halt  = 1'b0;
        m_err   = 1'b0;
        m_rd    = 32'h0;
        m_wr    = 32'h0;
    endtask

    task automatic check_outputs(input logic [31:0] a, input logic re);
        check_eq("bus_in",   {32'h0, bus_if.bus_in},  {32'h0, m_read(a, re)});
        check_eq("core_rst", {63'h0, bus_if.core_rst}, {63'h0, (m_phase != 2)});
        check_eq("ld_ready", {63'h0, bus_if.ld_ready}, {63'h0, (m_phase == 0)});
        check_eq("halted",   {63'h0, halted},   {63'h0, m_halt});
        check_eq("addr_err", {63'h0, addr_err}, {63'h0, m_err});
        check_eq("rd_cnt",   {32'h0, rd_cnt},   {32'h0, m_rd});
        check_eq("wr_cnt",   {32'h0, wr_cnt},   {32'h0, m_wr});
    endtask

    // One clock: drive, check combinational/registered outputs at negedge, advance model.
    task automatic cyc(input logic v, input logic [11:0] la, input logic [7:0] ld, input logic ll,
                       input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [7:0] op);
        logic oor;
        logic [11:0] base;
        bus_if.ld_valid       = v;
        bus_if.ld_addr        = la;
        bus_if.ld_data        = ld;
        bus_if.ld_last        = ll;
        bus_if.bus_A          = a;
        bus_if.bus_out        = wd;
        bus_if.bus_WE         = we;
        bus_if.bus_RE         = re;
        bus_if.current_opcode = op;
        @(negedge clk);
        check_outputs(a, re);
        case (m_phase)
            0: if (v) begin
                m_mem[la] = ld;
                if (ll) m_phase = 1;
            end
            1: m_phase = 2;
            default: begin
                oor  = (a[31:12] != 20'h0);
                base = a[11:0];
                if ((we || re) && oor) m_err = 1'b1;
                if (we && re)          m_err = 1'b1;
                if (op == 8'hF4)       m_halt = 1'b1;
                if (we && !oor) begin
                    for (int k = 0; k < 4; k++) m_mem[base + 12'(k)] = wd[8*k +: 8];
                    if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
                end
                if (re && !oor && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run_cyc(input logic allow_halt);
        logic [31:0] a;
        logic [7:0]  op;
        a  = ($urandom_range(5) == 0) ? $urandom : {20'h0, 12'($urandom)};
        op = allow_halt ? 8'($urandom) : 8'($urandom_range(0, 8'hF3));
        cyc(1'($urandom), 12'($urandom), 8'($urandom), 1'($urandom), a, $urandom,
            ($urandom_range(2) == 0), ($urandom_range(1) == 0) || ($urandom_range(3) == 0), op);
    endtask

    task automatic load_gap();
        while ($urandom_range(3) == 0)
            cyc(1'b0, 12'($urandom), 8'($urandom), 1'($urandom), $urandom, $urandom,
                1'($urandom), 1'($urandom), ($urandom_range(1) == 0) ? 8'hF4 : 8'($urandom));
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        bus_if.ld_valid = 1'b0; bus_if.ld_addr = '0; bus_if.ld_data = '0; bus_if.ld_last = 1'b0;
        bus_if.bus_A = 32'h0; bus_if.bus_out = 32'h0; bus_if.bus_WE = 1'b0;
        bus_if.bus_RE = 1'b1; bus_if.current_opcode = 8'hF4;
        m_reset();
        repeat (2) @(posedge clk);
        #2;
        check_outputs(32'h0, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill the whole array so every later read has a defined expectation.
        for (int i = 0; i < MEM_SZ; i++) begin
            load_gap();
            b = (i == 0) ? 8'h01 : (i == 1) ? 8'hC0 : (i == 2) ? 8'hF4 : 8'($urandom);
            cyc(1'b1, 12'(i), b, (i == MEM_SZ - 1), $urandom, $urandom,
                1'($urandom), 1'b1, 8'hF4);
        end
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 8'hF4);      // RELEASE
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h00);      // read F4C001
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'hFFE, 32'h11223344, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'hFFE, 32'h0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h00);       // wrapped bytes at 0..1
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h1000, 32'hCAFEF00D, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h20, 32'h55AA55AA, 1'b1, 1'b1, 8'h00); // WE+RE together
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 150; i++) run_cyc(1'b0);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'hF4);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 150; i++) run_cyc(1'b1);

        // Asynchronous reset in the middle of a RUN cycle.
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check_outputs(32'h0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 12'h500, 8'h3C, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 8'hF4);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 32'h4FE, 32'h0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 200; i++) run_cyc(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule
`default_nettype wire
